mb128_spi_mem: RTL and testbench

- Downstream storage engine for the MB128 emulator core. It turns the core's decoded transfer requests into SPI transactions on the external 1 Mbit serial FRAM/SRAM (sp_* pins).
- Runs the power-up write-unlock sequence. Streams bytes one at a time under handshake, because the joypad side consumes bits far slower than SPI delivers them.
- The core supplies a 17-bit byte address (10-bit block address × 128) and then requests or supplies bytes until it ends the transfer.

---
 rtl/mb128_spi_mem.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mb128_spi_mem.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb128_spi_mem.sv
// ---------------------------------------------------------------------------
// mb128_spi_mem
//
// Storage back end for the MB128 emulator core. Converts the core's transfer
// requests into SPI mode-0 transactions on a 1 Mbit serial FRAM/SRAM. After
// reset it unlocks the device for writing (WREN, then WRSR 0x00). Afterwards
// each transfer is opened with a header (optional WREN, opcode, 24-bit
// address). The data bytes then move one at a time under handshake, so the
// slow joypad side sets the pace. Chip select stays low while the transfer
// is open. The device auto-increments the address itself.
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   i_cmd_valid  pulse, open a transfer (honoured only while o_ready)
//   i_cmd_write  1 = write transfer, 0 = read transfer
//   i_cmd_addr   17-bit start byte address
//   i_byte_req   pulse, move one byte (honoured only while o_open)
//   i_wr_data    byte to write, sampled with i_byte_req
//   i_end        pulse, close the transfer
//   o_rd_data    last byte read from the device
//   o_rd_valid   one-cycle pulse when o_rd_data updates
//   o_ready      init done and idle
//   o_open       transfer open, waiting for byte requests
//   o_busy       init or shifting in progress
//   sp_cs_n      SPI chip select, active low
//   sp_clk       SPI clock, idles low
//   sp_mosi      SPI data out, MSB first
//   sp_miso      SPI data in
//   sp_hold_n    SPI hold, tied inactive
// ---------------------------------------------------------------------------
module mb128_spi_mem #(
    parameter int CLK_DIV   = 2,
    parameter int CS_GAP    = 4,
    parameter int INIT_WAIT = 32
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_cmd_valid,
    input  logic        i_cmd_write,
    input  logic [16:0] i_cmd_addr,
    input  logic        i_byte_req,
    input  logic [7:0]  i_wr_data,
    input  logic        i_end,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_ready,
    output logic        o_open,
    output logic        o_busy,
    output logic        sp_cs_n,
    output logic        sp_clk,
    output logic        sp_mosi,
    input  logic        sp_miso,
    output logic        sp_hold_n
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_WREN,
        ST_INIT_WRSR,
        ST_IDLE,
        ST_WR_WREN,
        ST_HDR,
        ST_OPEN,
        ST_XFER,
        ST_CLOSE
    } state_t;

    // Phase of the shift engine inside a shifting state.
    typedef enum logic [1:0] {
        SUB_LOW,    // sp_clk low, MOSI already valid for the current bit
        SUB_HIGH,   // sp_clk high, MISO already captured
        SUB_TRAIL,  // last bit done, CS still low for CLK_DIV cycles
        SUB_GAP     // CS high, enforcing the inter-transaction gap
    } sub_t;

    state_t      state_q, state_d;
    sub_t        sub_q, sub_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  bits_q, bits_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        wr_mode_q, wr_mode_d;
    logic [16:0] addr_q, addr_d;
    logic        end_pend_q, end_pend_d;

    logic        start_tx;
    logic [31:0] start_word;
    logic [5:0]  start_bits;

    // State and datapath registers; reset returns every pin to its idle level
    // at once and restarts the unlock sequence, abandoning any partial byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT_WAIT;
            sub_q      <= SUB_LOW;
            cnt_q      <= '0;
            bits_q     <= '0;
            shift_q    <= '0;
            rx_q       <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_mode_q  <= 1'b0;
            addr_q     <= '0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_mode_q  <= wr_mode_d;
            addr_q     <= addr_d;
            end_pend_q <= end_pend_d;
        end
    end

    // Next-state logic. Shifting states share one bit engine. A state that
    // starts a burst loads a left-aligned word. The word's MSB drives MOSI
    // straight away, and CS drops in the same cycle, so CS falls CLK_DIV
    // cycles before the first rising edge.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_mode_d  = wr_mode_q;
        addr_d     = addr_q;
        end_pend_d = end_pend_q;
        start_tx   = 1'b0;
        start_word = '0;
        start_bits = '0;

        case (state_q)
            ST_INIT_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d    = ST_INIT_WREN;
                    start_tx   = 1'b1;
                    start_word = {8'h06, 24'h0};
                    start_bits = 6'd8;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_IDLE: begin
                end_pend_d = 1'b0;
                if (i_cmd_valid) begin
                    wr_mode_d = i_cmd_write;
                    addr_d    = i_cmd_addr;
                    start_tx  = 1'b1;
                    if (i_cmd_write) begin
                        state_d    = ST_WR_WREN;
                        start_word = {8'h06, 24'h0};
                        start_bits = 6'd8;
                    end else begin
                        state_d    = ST_HDR;
                        start_word = {8'h03, 7'b0, i_cmd_addr};
                        start_bits = 6'd32;
                    end
                end
            end

            // A byte request wins over a simultaneous end; the end is kept
            // pending and honoured once the byte has been shifted.
            ST_OPEN: begin
                if (i_byte_req) begin
                    state_d    = ST_XFER;
                    end_pend_d = i_end;
                    start_tx   = 1'b1;
                    start_word = {(wr_mode_q ? i_wr_data : 8'h00), 24'h0};
                    start_bits = 6'd8;
                end else if (i_end) begin
                    state_d = ST_CLOSE;
                    sub_d   = SUB_TRAIL;
                    cnt_d   = '0;
                end
            end

            default: begin
                if (state_q == ST_XFER && i_end) begin
                    end_pend_d = 1'b1;
                end
                case (sub_q)
                    SUB_LOW: begin
                        if (cnt_q == DIV_LAST) begin
                            sclk_d = 1'b1;
                            rx_d   = {rx_q[6:0], sp_miso};
                            cnt_d  = '0;
                            sub_d  = SUB_HIGH;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end

                    SUB_HIGH: begin
                        if (cnt_q == DIV_LAST) begin
                            sclk_d = 1'b0;
                            cnt_d  = '0;
                            if (bits_q == 6'd1) begin
                                bits_d  = '0;
                                shift_d = '0;
                                sub_d   = SUB_LOW;
                                if (state_q == ST_HDR) begin
                                    state_d = ST_OPEN;
                                end else if (state_q == ST_XFER) begin
                                    if (!wr_mode_q) begin
                                        rd_data_d  = rx_q;
                                        rd_valid_d = 1'b1;
                                    end
                                    if (end_pend_q || i_end) begin
                                        state_d = ST_CLOSE;
                                        sub_d   = SUB_TRAIL;
                                    end else begin
                                        state_d = ST_OPEN;
                                    end
                                end else begin
                                    sub_d = SUB_TRAIL;
                                end
                            end else begin
                                bits_d  = bits_q - 6'd1;
                                shift_d = {shift_q[30:0], 1'b0};
                                sub_d   = SUB_LOW;
                            end
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end

                    SUB_TRAIL: begin
                        if (cnt_q == DIV_LAST) begin
                            cs_n_d = 1'b1;
                            cnt_d  = '0;
                            sub_d  = SUB_GAP;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end

                    default: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_d = '0;
                            sub_d = SUB_LOW;
                            case (state_q)
                                ST_INIT_WREN: begin
                                    state_d    = ST_INIT_WRSR;
                                    start_tx   = 1'b1;
                                    start_word = {8'h01, 8'h00, 16'h0};
                                    start_bits = 6'd16;
                                end
                                ST_WR_WREN: begin
                                    state_d    = ST_HDR;
                                    start_tx   = 1'b1;
                                    start_word = {8'h02, 7'b0, addr_q};
                                    start_bits = 6'd32;
                                end
                                default: begin
                                    state_d = ST_IDLE;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                endcase
            end
        endcase

        if (start_tx) begin
            shift_d = start_word;
            bits_d  = start_bits;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            cnt_d   = '0;
            sub_d   = SUB_LOW;
        end
    end

    assign sp_cs_n    = cs_n_q;
    assign sp_clk     = sclk_q;
    assign sp_mosi    = shift_q[31];
    assign sp_hold_n  = 1'b1;
    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_ready    = (state_q == ST_IDLE);
    assign o_open     = (state_q == ST_OPEN);
    assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_OPEN);

endmodule

// File: tb/tb_mb128_spi_mem.sv
// ---------------------------------------------------------------------------
// tb_mb128_spi_mem
//
// Directed self-checking bench for mb128_spi_mem (CLK_DIV=2, CS_GAP=4,
// INIT_WAIT=32). A small SPI device model captures MOSI bytes, counts
// chip-select transactions, measures CS-high gaps and sp_clk period, and
// returns 0x62 then 0xC3 as the first two data bytes after a 32-bit header.
// ---------------------------------------------------------------------------
module tb_mb128_spi_mem;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        i_cmd_write = 1'b0;
    logic [16:0] i_cmd_addr = '0;
    logic        i_byte_req = 1'b0;
    logic [7:0]  i_wr_data = '0;
    logic        i_end = 1'b0;
    logic [7:0]  o_rd_data;
    logic        o_rd_valid;
    logic        o_ready;
    logic        o_open;
    logic        o_busy;
    logic        sp_cs_n;
    logic        sp_clk;
    logic        sp_mosi;
    logic        sp_miso = 1'b0;
    logic        sp_hold_n;

    int errors = 0;
    int checks = 0;

    mb128_spi_mem #(.CLK_DIV(2), .CS_GAP(4), .INIT_WAIT(32)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_cmd_valid(i_cmd_valid),
        .i_cmd_write(i_cmd_write),
        .i_cmd_addr (i_cmd_addr),
        .i_byte_req (i_byte_req),
        .i_wr_data  (i_wr_data),
        .i_end      (i_end),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_ready    (o_ready),
        .o_open     (o_open),
        .o_busy     (o_busy),
        .sp_cs_n    (sp_cs_n),
        .sp_clk     (sp_clk),
        .sp_mosi    (sp_mosi),
        .sp_miso    (sp_miso),
        .sp_hold_n  (sp_hold_n)
    );

    always #5 clk_sys = ~clk_sys;

    // Device model state.
    logic [7:0] cap[$];
    logic [7:0] miso_data[2];
    logic [7:0] sr = '0;
    int         nb = 0;
    int         rises = 0;
    int         cs_falls = 0;
    realtime    last_rise_t = 0;
    realtime    last_period = 0;
    logic       prev_cs = 1'b1;
    logic       prev_clk = 1'b0;
    int         hi_cnt = 0;
    int         last_gap = 0;
    int         rv_cnt = 0;

    initial begin
        miso_data[0] = 8'h62;
        miso_data[1] = 8'hC3;
    end

    function automatic logic misoBit(input int n);
        int k;
        if (n < 32) return 1'b0;
        k = n - 32;
        if (k >= 16) return 1'b0;
        return miso_data[k / 8][7 - (k % 8)];
    endfunction

    // SPI slave: capture MOSI on rising sp_clk, present MISO after CS fall
    // and after each falling sp_clk.
    always @(sp_cs_n or sp_clk) begin
        if (prev_cs === 1'b1 && sp_cs_n === 1'b0) begin
            rises    = 0;
            nb       = 0;
            cs_falls = cs_falls + 1;
            sp_miso  = misoBit(0);
        end
        if (prev_clk === 1'b0 && sp_clk === 1'b1) begin
            if (rises > 0) last_period = $realtime - last_rise_t;
            last_rise_t = $realtime;
            rises = rises + 1;
            sr    = {sr[6:0], sp_mosi};
            nb    = nb + 1;
            if (nb == 8) begin
                cap.push_back(sr);
                nb = 0;
            end
        end
        if (prev_clk === 1'b1 && sp_clk === 1'b0) begin
            sp_miso = misoBit(rises);
        end
        prev_cs  = sp_cs_n;
        prev_clk = sp_clk;
    end

    // CS-high duration in clk_sys cycles and o_rd_valid pulse count.
    always @(negedge clk_sys) begin
        if (sp_cs_n) begin
            hi_cnt = hi_cnt + 1;
        end else begin
            if (hi_cnt != 0) last_gap = hi_cnt;
            hi_cnt = 0;
        end
        if (o_rd_valid) rv_cnt = rv_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic cw, input logic [16:0] ad,
                                 input logic br, input logic [7:0] wd, input logic en);
        @(negedge clk_sys);
        i_cmd_valid = cv;
        i_cmd_write = cw;
        i_cmd_addr  = ad;
        i_byte_req  = br;
        i_wr_data   = wd;
        i_end       = en;
        @(posedge clk_sys);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_byte_req  = 1'b0;
        i_end       = 1'b0;
    endtask

    // which: 0 o_ready, 1 o_open, 2 o_rd_valid, 3 sp_cs_n high
    task automatic waitCond(input int which, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_sys);
            case (which)
                0:       ok = o_ready;
                1:       ok = o_open;
                2:       ok = o_rd_valid;
                default: ok = sp_cs_n;
            endcase
        end
    endtask

    initial begin
        logic ok;
        int   base;
        int   falls0;
        int   rv0;

        // Reset values
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("rst_pins", {29'b0, sp_cs_n, sp_clk, sp_mosi}, 32'h4);
        checkOutput("rst_hold", {31'b0, sp_hold_n}, 32'h1);
        checkOutput("rst_status", {28'b0, o_rd_valid, o_ready, o_open, o_busy}, 32'h1);
        checkOutput("rst_rdata", {24'b0, o_rd_data}, 32'h0);

        // Init sequence; a command during INIT_WAIT must be ignored
        base   = cap.size();
        falls0 = cs_falls;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        checkOutput("initwait_cs", {31'b0, sp_cs_n}, 32'h1);
        applyStimulus(1'b1, 1'b0, 17'h00010, 1'b0, 8'h00, 1'b0);
        waitCond(0, 500, ok);
        checkOutput("init_ready", {31'b0, ok}, 32'h1);
        checkOutput("init_nbytes", cap.size() - base, 32'd3);
        checkOutput("init_bytes", {8'h0, cap[base], cap[base+1], cap[base+2]}, 32'h00060100);
        checkOutput("init_txns", cs_falls - falls0, 32'd2);
        checkOutput("init_gap_ge4", {31'b0, (last_gap >= 4)}, 32'h1);
        checkOutput("sclk_period", int'(last_period), 32'd40);
        checkOutput("idle_busy", {31'b0, o_busy}, 32'h0);

        // Byte request in IDLE does nothing
        falls0 = cs_falls;
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b1, 8'hAA, 1'b0);
        repeat (20) @(negedge clk_sys);
        checkOutput("idle_breq_txns", cs_falls - falls0, 32'd0);
        checkOutput("idle_breq_ready", {31'b0, o_ready}, 32'h1);

        // Read two bytes from 0x05280
        base   = cap.size();
        falls0 = cs_falls;
        rv0    = rv_cnt;
        applyStimulus(1'b1, 1'b0, 17'h05280, 1'b0, 8'h00, 1'b0);
        waitCond(1, 400, ok);
        checkOutput("rd_open", {31'b0, ok}, 32'h1);
        checkOutput("rd_hdr", {cap[base], cap[base+1], cap[base+2], cap[base+3]}, 32'h03005280);
        checkOutput("rd_open_pins", {30'b0, sp_cs_n, sp_clk}, 32'h0);
        applyStimulus(1'b1, 1'b1, 17'h00001, 1'b0, 8'h00, 1'b0);
        repeat (10) @(negedge clk_sys);
        checkOutput("open_cmd_ignored", {31'b0, o_open}, 32'h1);
        checkOutput("open_cmd_nbytes", cap.size() - base, 32'd4);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b1, 8'h00, 1'b0);
        waitCond(2, 200, ok);
        checkOutput("rd_byte0_valid", {31'b0, ok}, 32'h1);
        checkOutput("rd_byte0", {24'b0, o_rd_data}, 32'h62);
        waitCond(1, 10, ok);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b1, 8'h00, 1'b0);
        waitCond(2, 200, ok);
        checkOutput("rd_byte1_valid", {31'b0, ok}, 32'h1);
        checkOutput("rd_byte1", {24'b0, o_rd_data}, 32'hC3);
        waitCond(1, 10, ok);
        checkOutput("rd_cs_held", {31'b0, sp_cs_n}, 32'h0);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b0, 8'h00, 1'b1);
        waitCond(0, 100, ok);
        checkOutput("rd_close_ready", {31'b0, ok}, 32'h1);
        checkOutput("rd_cs_high", {31'b0, sp_cs_n}, 32'h1);
        checkOutput("rd_valid_count", rv_cnt - rv0, 32'd2);
        checkOutput("rd_txns", cs_falls - falls0, 32'd1);

        // Write 0xC3 to 0x05280
        base = cap.size();
        rv0  = rv_cnt;
        applyStimulus(1'b1, 1'b1, 17'h05280, 1'b0, 8'h00, 1'b0);
        waitCond(1, 400, ok);
        checkOutput("wr_open", {31'b0, ok}, 32'h1);
        checkOutput("wr_wren", {24'b0, cap[base]}, 32'h06);
        checkOutput("wr_gap_ge4", {31'b0, (last_gap >= 4)}, 32'h1);
        checkOutput("wr_hdr", {cap[base+1], cap[base+2], cap[base+3], cap[base+4]}, 32'h02005280);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b1, 8'hC3, 1'b0);
        waitCond(1, 200, ok);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b0, 8'h00, 1'b1);
        waitCond(0, 100, ok);
        checkOutput("wr_ready", {31'b0, ok}, 32'h1);
        checkOutput("wr_nbytes", cap.size() - base, 32'd6);
        checkOutput("wr_data", {24'b0, cap[base+5]}, 32'hC3);
        checkOutput("wr_no_rvalid", rv_cnt - rv0, 32'd0);

        // Read at top address, end issued mid-byte, command during CS gap
        base   = cap.size();
        falls0 = cs_falls;
        rv0    = rv_cnt;
        applyStimulus(1'b1, 1'b0, 17'h1FFFF, 1'b0, 8'h00, 1'b0);
        waitCond(1, 400, ok);
        checkOutput("top_hdr", {cap[base], cap[base+1], cap[base+2], cap[base+3]}, 32'h0301FFFF);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b1, 8'h00, 1'b0);
        repeat (8) @(negedge clk_sys);
        applyStimulus(1'b0, 1'b0, 17'h0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_end_cs_low", {31'b0, sp_cs_n}, 32'h0);
        waitCond(3, 100, ok);
        checkOutput("mid_end_cs_rise", {31'b0, ok}, 32'h1);
        checkOutput("mid_end_byte", {24'b0, o_rd_data}, 32'h62);
        checkOutput("mid_end_rvalid", rv_cnt - rv0, 32'd1);
        checkOutput("mid_end_nbytes", cap.size() - base, 32'd5);
        applyStimulus(1'b1, 1'b0, 17'h00100, 1'b0, 8'h00, 1'b0);
        repeat (20) @(negedge clk_sys);
        checkOutput("gap_cmd_ignored", cs_falls - falls0, 32'd1);
        checkOutput("gap_cmd_ready", {31'b0, o_ready}, 32'h1);

        // Reset during header bit 10
        applyStimulus(1'b1, 1'b0, 17'h05280, 1'b0, 8'h00, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_sys);
            ok = (sp_cs_n === 1'b0) && (rises >= 10);
        end
        checkOutput("hdr_bit10_reached", {31'b0, ok}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_pins", {30'b0, sp_cs_n, sp_clk}, 32'h2);
        checkOutput("async_rst_status", {29'b0, o_ready, o_open, o_busy}, 32'h1);
        repeat (3) @(negedge clk_sys);
        base   = cap.size();
        falls0 = cs_falls;
        reset_n = 1'b1;
        waitCond(0, 500, ok);
        checkOutput("reinit_ready", {31'b0, ok}, 32'h1);
        checkOutput("reinit_bytes", {8'h0, cap[base], cap[base+1], cap[base+2]}, 32'h00060100);
        checkOutput("reinit_txns", cs_falls - falls0, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
